// File: rtl/lab3_g29_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab3_g29_pkg
// Description : Shared constants, types and helpers for the lab3 group-29
//               nibble demultiplexer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package lab3_g29_pkg;

  localparam int DATA_W = 4;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [DATA_W-1:0] nibble_t;
  typedef logic [SEL_W-1:0]  ch_sel_t;

  // One-hot decode of a channel select
  function automatic logic [NUM_CH-1:0] sel_decode(input ch_sel_t sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab3_g29_p3_demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : lab3_g29_p3_demux_slot
// Description : One demux channel: holding register plus valid flag. A load
//               always wins over a same-cycle ack; an ack only drops the
//               valid flag and leaves the stored word in place.
// Revision    : 1.0 - initial release
// ============================================================================
module lab3_g29_p3_demux_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  // Next-state: load replaces data and sets valid; ack clears valid only
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ack_i;
    if (load_i) begin
      data_d  = d_i;
      valid_d = 1'b1;
    end
  end

  // Channel storage, emptied asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/lab3_g29_p3_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : lab3_g29_p3_demux_1x8
// Description : Registered 1-to-8 nibble demultiplexer with valid/ready input
//               handshake, per-channel holding registers released by acks,
//               and a saturating stall counter.
//               Optional macro LAB3_G29_DEMUX_AUTOSEL_EN replaces in_sel with
//               an internal round-robin pointer that never skips a channel.
// Revision    : 1.0 - initial release
// ============================================================================
module lab3_g29_p3_demux_1x8 #(
  parameter int DATA_W      = 4,
  parameter int NUM_CH      = 8,
  parameter int STALL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [2:0]               in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ack,
  output logic [2:0]               cur_sel,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  import lab3_g29_pkg::*;

  ch_sel_t                  w_tgt;
  logic                     w_xfer;
  logic [NUM_CH-1:0]        w_load;
  logic [STALL_CNT_W-1:0]   stall_q;
  logic [STALL_CNT_W-1:0]   stall_d;

`ifdef LAB3_G29_DEMUX_AUTOSEL_EN
  ch_sel_t ptr_q;
  ch_sel_t ptr_d;
  logic    unused_in_sel;

  // The source select is ignored when the pointer chooses the target
  assign unused_in_sel = ^in_sel;

  // Pointer advances only on an accepted transfer, so a full channel holds it
  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      ptr_d = ptr_q + 3'd1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign w_tgt = ptr_q;
`else
  assign w_tgt = in_sel;
`endif

  assign cur_sel = w_tgt;

  // A full channel that is acked this cycle can be refilled in the same cycle
  assign in_ready = ~out_valid[w_tgt] | out_ack[w_tgt];
  assign w_xfer   = in_valid & in_ready;
  assign w_load   = w_xfer ? sel_decode(w_tgt) : '0;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      lab3_g29_p3_demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load[k]),
        .ack_i   (out_ack[k]),
        .d_i     (in_data),
        .q_o     (out_data[k*DATA_W +: DATA_W]),
        .valid_o (out_valid[k])
      );
    end
  endgenerate

  // Stall counter steps on blocked offers and sticks at all-ones
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_g29_p3_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab3_g29_p3_demux_1x8
// Description : Directed self-checking bench for lab3_g29_p3_demux_1x8.
//               Follows LAB3_G29_DEMUX_AUTOSEL_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab3_g29_p3_demux_1x8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [2:0]  cur_sel;
  logic [7:0]  stall_cnt;

  int n_checks;
  int n_errors;

  lab3_g29_p3_demux_1x8 #(
    .DATA_W      (4),
    .NUM_CH      (8),
    .STALL_CNT_W (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .cur_sel   (cur_sel),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle write of one word to a channel
  task automatic put(input logic [2:0] sel, input logic [3:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    out_ack  = '0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  out_data,       32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_cursel", 32'(cur_sel),  32'h0);
    rst_n = 1'b1;
    step();

`ifdef LAB3_G29_DEMUX_AUTOSEL_EN
    // Nine back-to-back writes with every ack high: wrap 7 -> 0 -> 1
    out_ack  = 8'hFF;
    in_sel   = 3'd5;
    in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = 4'(i);
      #1;
      chk("auto_cursel", 32'(cur_sel),  32'((i - 1) % 8));
      chk("auto_ready",  32'(in_ready), 32'h1);
      step();
    end
    in_valid = 1'b0;
    out_ack  = 8'h00;
    chk("auto_data",    out_data,       32'h8765_4329);
    chk("auto_valid",   32'(out_valid), 32'h01);
    chk("auto_wrap",    32'(cur_sel),   32'h1);

    // Fill channels 1..7 without acks; pointer returns to full channel 0
    for (int i = 1; i <= 7; i++) begin
      put(3'd0, 4'hB);
    end
    chk("auto_fullv",   32'(out_valid), 32'hFF);
    in_valid = 1'b1;
    #1;
    chk("auto_block",   32'(in_ready),  32'h0);
    step();
    step();
    chk("auto_hold",    32'(cur_sel),   32'h0);
    chk("auto_stall",   32'(stall_cnt), 32'h2);
    chk("auto_ch0",     32'(out_data[3:0]), 32'h9);

    // Mid-run reset clears pointer and channels without waiting for an edge
    in_valid = 1'b0;
    put(3'd0, 4'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("auto_rst_sel", 32'(cur_sel),   32'h0);
    chk("auto_rst_val", 32'(out_valid), 32'h0);
    chk("auto_rst_dat", out_data,       32'h0);
    step();
    rst_n = 1'b1;
`else
    // Single write: channel 5 gets 0xA, one cycle latency
    in_sel   = 3'd5;
    in_data  = 4'hA;
    in_valid = 1'b1;
    #1;
    chk("w1_cursel", 32'(cur_sel),  32'h5);
    chk("w1_ready",  32'(in_ready), 32'h1);
    chk("w1_prevld", 32'(out_valid), 32'h0);
    step();
    in_valid = 1'b0;
    chk("w1_valid",  32'(out_valid), 32'h20);
    chk("w1_data",   out_data,       32'h00A0_0000);

    // Full channel 2 stalls a second word for four cycles
    put(3'd2, 4'h3);
    in_sel   = 3'd2;
    in_data  = 4'h7;
    in_valid = 1'b1;
    #1;
    chk("st_ready",  32'(in_ready), 32'h0);
    repeat (4) step();
    in_valid = 1'b0;
    chk("st_cnt",    32'(stall_cnt), 32'h4);
    chk("st_data",   out_data,       32'h00A0_0300);
    chk("st_valid",  32'(out_valid), 32'h24);

    // Pass-through refill: ack and new word in the same cycle
    in_sel   = 3'd2;
    in_data  = 4'h9;
    in_valid = 1'b1;
    out_ack  = 8'h04;
    #1;
    chk("pt_ready",  32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    out_ack  = 8'h00;
    chk("pt_valid",  32'(out_valid), 32'h24);
    chk("pt_data",   out_data,       32'h00A0_0900);

    // Ack on an empty channel is ignored
    out_ack = 8'h02;
    step();
    out_ack = 8'h00;
    chk("ea_valid",  32'(out_valid), 32'h24);

    // Multi-ack on channels 0, 3 and 7
    put(3'd0, 4'h1);
    put(3'd3, 4'h6);
    put(3'd7, 4'hF);
    chk("ma_pre",    32'(out_valid), 32'hAD);
    chk("ma_data",   out_data,       32'hF0A0_6901);
    out_ack = 8'h89;
    step();
    chk("ma_valid",  32'(out_valid), 32'h24);
    out_ack = 8'h24;
    step();
    out_ack = 8'h00;
    chk("ma_empty",  32'(out_valid), 32'h00);
    chk("ma_keep",   out_data,       32'hF0A0_6901);

    // Ready follows sel/ack even with no offer
    put(3'd4, 4'hC);
    in_sel = 3'd4;
    #1;
    chk("rdy_full",  32'(in_ready), 32'h0);
    out_ack = 8'h10;
    #1;
    chk("rdy_ack",   32'(in_ready), 32'h1);
    step();
    out_ack = 8'h00;
    chk("rdy_clr",   32'(out_valid), 32'h00);
    chk("rdy_data",  out_data,       32'hF0AC_6901);

    // Saturation: blocked offer for 300 cycles
    put(3'd6, 4'h5);
    in_sel   = 3'd6;
    in_data  = 4'h2;
    in_valid = 1'b1;
    repeat (300) step();
    chk("sat_cnt",   32'(stall_cnt), 32'hFF);
    repeat (5) step();
    chk("sat_hold",  32'(stall_cnt), 32'hFF);
    chk("sat_data",  out_data,       32'hF5AC_6901);

    // Reset asserted while a transfer is being offered
    in_sel   = 3'd1;
    in_data  = 4'hE;
    in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_valid",  32'(out_valid), 32'h00);
    chk("mr_data",   out_data,       32'h0);
    chk("mr_stall",  32'(stall_cnt), 32'h0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("mr_after",  32'(out_valid), 32'h00);
    chk("mr_adata",  out_data,       32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
